sig_dump: RTL and testbench
===========================

SIG_DUMP -- requirements
Module: sig_dump

Interface
REQ-001 Parameter SIG_BEGIN, default 32'h00005000: byte address of the first signature word (word-aligned).
REQ-002 Parameter SIG_END, default 32'h00008000: exclusive byte end address of the signature region (word-aligned, >= SIG_BEGIN).
REQ-003 Parameter TOHOST_ADDR, default 32'h00005000: byte address the core writes to signal completion.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mem_we  input  1  core data-memory write strobe (snooped, not driven).
REQ-007 mem_waddr  input  32  core data-memory write byte address.
REQ-008 mem_wdata  input  32  core data-memory write data.
REQ-009 halt  output  1  request to freeze the core once completion is detected.
REQ-010 rd_en  output  1  read strobe to a second data-memory read port.
REQ-011 rd_addr  output  32  byte address for rd_en.
REQ-012 rd_data  input  32  read data, valid exactly one cycle after rd_en.
REQ-013 tx_valid  output  1  output stream word valid.
REQ-014 tx_data  output  32  output stream word.
REQ-015 tx_ready  input  1  downstream accepts the word when tx_valid && tx_ready.
REQ-016 done  output  1  signature fully transmitted; sticky until reset.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, SEND, DONE.
REQ-018 In IDLE, a cycle with mem_we=1, mem_waddr==TOHOST_ADDR and mem_wdata==32'h1 SHALL trigger; at the next edge halt=1, pointer=SIG_BEGIN, state=READ.
REQ-019 A tohost write with any data other than 32'h1, or any write outside IDLE, SHALL be ignored.
REQ-020 If SIG_BEGIN==SIG_END, the trigger SHALL go directly to DONE with zero words sent.
REQ-021 READ SHALL assert rd_en=1 and rd_addr=pointer for exactly one cycle, then enter WAIT.
REQ-022 WAIT SHALL capture rd_data into a holding register and enter SEND; the captured word appears on tx_data in the next cycle.
REQ-023 In SEND, tx_valid=1 and tx_data SHALL stay stable until tx_ready=1; tx_valid SHALL NOT drop before acceptance.
REQ-024 On acceptance, pointer SHALL increment by 4; if the new pointer==SIG_END, go to DONE, else go to READ.
REQ-025 Words SHALL be sent in ascending address order, last word at SIG_END-4; throughput is at most one word per 3 cycles.
REQ-026 In DONE, done=1, halt=1, tx_valid=0 and rd_en=0, held until reset; further tohost writes have no effect.
REQ-027 halt SHALL stay 1 from the cycle after trigger until reset.
REQ-028 The pointer SHALL be 32 bits wide; comparison with SIG_END SHALL use full-width equality (no wrap beyond SIG_END).

Reset
REQ-029 When rst=1 at a posedge, state=IDLE, and halt, rd_en, tx_valid and done SHALL be 0; rd_addr, tx_data and pointer SHALL be 0.
REQ-030 Reset SHALL take priority over a simultaneous trigger and SHALL abort a dump in progress, dropping tx_valid at the next edge.

Configuration
REQ-031 With SIG_DUMP_HDR_EN defined, a header word equal to (SIG_END-SIG_BEGIN)>>2 SHALL be sent with the SEND handshake before the first data word, in an extra state HDR entered on trigger.
REQ-032 With SIG_DUMP_HDR_EN defined and SIG_BEGIN==SIG_END, the header 32'h0 SHALL be sent, followed by DONE.
REQ-033 Without SIG_DUMP_HDR_EN, no header word or HDR state SHALL exist, and the stream SHALL contain only signature words.

Verification
REQ-034 SIG_BEGIN=0x100, SIG_END=0x10C, memory preloaded with AA,BB,CC, tx_ready=1, write 1 to TOHOST_ADDR -> tx_data sequence AA,BB,CC, rd_addr 0x100,0x104,0x108, then done=1.
REQ-035 Write 32'h2 to TOHOST_ADDR -> halt stays 0 and no rd_en; a following write of 32'h1 triggers normally.
REQ-036 Hold tx_ready=0 for 5 cycles during the first word -> tx_valid=1 and tx_data stable for all 5 cycles, no second rd_en, no lost or duplicated words.
REQ-037 SIG_BEGIN==SIG_END=0x200, then trigger -> done=1 two cycles after the trigger write, zero stream words (one 32'h0 header word with SIG_DUMP_HDR_EN).
REQ-038 Assert rst mid-dump after the second word -> next cycle all outputs are 0 and state is IDLE; a retrigger resends from SIG_BEGIN.
REQ-039 With SIG_DUMP_HDR_EN, region 0x100-0x10C -> first accepted word is 32'h3, followed by AA,BB,CC.

Source files
------------

// File: rtl/sig_dump.sv
// sig_dump: snoops core data-memory writes for a completion flag at TOHOST_ADDR.
// Once the flag arrives, it halts the core and streams every signature word
// in [SIG_BEGIN, SIG_END) out over a valid/ready interface.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   mem_we/waddr/wdata    snooped core write port (input only)
//   halt                  freeze request to the core, sticky after trigger
//   rd_en/rd_addr/rd_data second read port; data returns one cycle after rd_en
//   tx_valid/tx_data      output stream, held until tx_ready
//   tx_ready              downstream accept
//   done                  whole signature sent, sticky until reset
//
// Build option
//   SIG_DUMP_HDR_EN  when defined, a word-count header word is sent before the
//                    signature words.
module sig_dump #(
   parameter logic [31:0] SIG_BEGIN   = 32'h00005000,
   parameter logic [31:0] SIG_END     = 32'h00008000,
   parameter logic [31:0] TOHOST_ADDR = 32'h00005000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic [31:0] mem_waddr,
   input  logic [31:0] mem_wdata,
   output logic        halt,
   output logic        rd_en,
   output logic [31:0] rd_addr,
   input  logic [31:0] rd_data,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   output logic        done
);

`ifdef SIG_DUMP_HDR_EN
   typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StDone, StHdr} state_e;
   localparam logic [31:0] NumWords = (SIG_END - SIG_BEGIN) >> 2;
`else
   typedef enum logic [2:0] {StIdle, StRead, StWait, StSend, StDone} state_e;
`endif

   localparam bit Empty = (SIG_BEGIN == SIG_END);

   state_e      state_q;
   logic [31:0] ptr_q;
   logic [31:0] ptr_next;
   logic        trigger;

   assign trigger  = mem_we && (mem_waddr == TOHOST_ADDR) && (mem_wdata == 32'h1);
   assign ptr_next = ptr_q + 32'd4;

   // All outputs are registered and updated together with the state, so each
   // state's outputs are already valid in the first cycle spent in it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         halt     <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         done     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (trigger) begin
                  halt  <= 1'b1;
                  ptr_q <= SIG_BEGIN;
`ifdef SIG_DUMP_HDR_EN
                  state_q  <= StHdr;
                  tx_valid <= 1'b1;
                  tx_data  <= NumWords;
`else
                  if (Empty) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StRead;
                     rd_en   <= 1'b1;
                     rd_addr <= SIG_BEGIN;
                  end
`endif
               end
            end
`ifdef SIG_DUMP_HDR_EN
            StHdr: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (Empty) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StRead;
                     rd_en   <= 1'b1;
                     rd_addr <= ptr_q;
                  end
               end
            end
`endif
            StRead: begin
               rd_en   <= 1'b0;
               state_q <= StWait;
            end
            StWait: begin
               // rd_data is valid now, one cycle after the rd_en cycle
               tx_data  <= rd_data;
               tx_valid <= 1'b1;
               state_q  <= StSend;
            end
            StSend: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  ptr_q    <= ptr_next;
                  // Full-width equality: the pointer never runs past SIG_END
                  if (ptr_next == SIG_END) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StRead;
                     rd_en   <= 1'b1;
                     rd_addr <= ptr_next;
                  end
               end
            end
            StDone: begin
               halt     <= 1'b1;
               done     <= 1'b1;
               rd_en    <= 1'b0;
               tx_valid <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sig_dump.sv
// Scoreboard bench for sig_dump: drivers push expected stream words and read
// addresses into queues, monitors pop and compare on each handshake.
module tb_sig_dump;

   localparam logic [31:0] Tohost = 32'h00005000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2, mem_we, mem_we2, tx_ready;
   logic [31:0] mem_waddr, mem_wdata;

   logic        halt, rd_en, tx_valid, done;
   logic [31:0] rd_addr, tx_data;
   logic [31:0] rd_data = '0;

   logic        halt2, rd_en2, tx_valid2, done2;
   logic [31:0] rd_addr2, tx_data2;
   logic [31:0] rd_data2 = '0;

   sig_dump #(.SIG_BEGIN(32'h100), .SIG_END(32'h10C), .TOHOST_ADDR(Tohost)) dut (
      .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .halt(halt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .done(done)
   );

   sig_dump #(.SIG_BEGIN(32'h200), .SIG_END(32'h200), .TOHOST_ADDR(Tohost)) dut_empty (
      .clk(clk), .rst(rst2), .mem_we(mem_we2), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .halt(halt2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready), .done(done2)
   );

   // Second read port of the data memory, preloaded with the signature.
   always @(posedge clk) begin
      if (rd_en) begin
         case (rd_addr)
            32'h100: rd_data <= 32'h000000AA;
            32'h104: rd_data <= 32'h000000BB;
            32'h108: rd_data <= 32'h000000CC;
            default: rd_data <= 32'hDEADBEEF;
         endcase
      end
   end

   int n_vec = 0;
   int n_fail = 0;
   int acc_cnt = 0, rd_cnt = 0, acc_cnt2 = 0, rd_cnt2 = 0;
   logic [31:0] exp_tx[$];
   logic [31:0] exp_ra[$];
   logic [31:0] exp_tx2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic extra(input string name, input logic [31:0] act);
      n_vec++;
      n_fail++;
      $display("FAIL %s: got %h, required nothing", name, act);
   endtask

   // Monitor for the populated region.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("tx_valid_hold", {31'b0, tx_valid}, 32'h1);
               check("tx_data_hold", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
               acc_cnt++;
               if (exp_tx.size() == 0) extra("tx_extra_word", tx_data);
               else check("tx_data", tx_data, exp_tx.pop_front());
            end
            if (rd_en) begin
               rd_cnt++;
               if (exp_ra.size() == 0) extra("rd_extra", rd_addr);
               else check("rd_addr", rd_addr, exp_ra.pop_front());
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   // Monitor for the empty region.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst2) begin
            if (tx_valid2 && tx_ready) begin
               acc_cnt2++;
               if (exp_tx2.size() == 0) extra("empty_tx_extra", tx_data2);
               else check("empty_tx_data", tx_data2, exp_tx2.pop_front());
            end
            if (rd_en2) rd_cnt2++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] d, input bit second);
      mem_waddr = Tohost;
      mem_wdata = d;
      if (second) mem_we2 = 1'b1;
      else mem_we = 1'b1;
      tick(1);
      mem_we  = 1'b0;
      mem_we2 = 1'b0;
   endtask

   task automatic push_all();
`ifdef SIG_DUMP_HDR_EN
      exp_tx.push_back(32'h3);
`endif
      exp_tx.push_back(32'h000000AA);
      exp_tx.push_back(32'h000000BB);
      exp_tx.push_back(32'h000000CC);
      exp_ra.push_back(32'h100);
      exp_ra.push_back(32'h104);
      exp_ra.push_back(32'h108);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 80; i++) begin
         if (done) break;
         tick(1);
      end
      check(name, {31'b0, done}, 32'h1);
   endtask

   task automatic reset1();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_halt"}, {31'b0, halt}, 32'h0);
      check({tag, "_rd_en"}, {31'b0, rd_en}, 32'h0);
      check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'h0);
      check({tag, "_done"}, {31'b0, done}, 32'h0);
      check({tag, "_rd_addr"}, rd_addr, 32'h0);
      check({tag, "_tx_data"}, tx_data, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int rc, a0;
      rst = 1'b1; rst2 = 1'b1;
      mem_we = 1'b0; mem_we2 = 1'b0; mem_waddr = '0; mem_wdata = '0;
      tx_ready = 1'b1;
      tick(2);
      check_idle("reset");
      check("reset_empty_done", {31'b0, done2}, 32'h0);
      rst = 1'b0; rst2 = 1'b0;
      tick(1);

      // Empty region: done within two edges of the trigger write.
`ifdef SIG_DUMP_HDR_EN
      exp_tx2.push_back(32'h0);
`endif
      wr(32'h1, 1'b1);
      tick(1);
      check("empty_done", {31'b0, done2}, 32'h1);
      check("empty_halt", {31'b0, halt2}, 32'h1);
      tick(4);
`ifdef SIG_DUMP_HDR_EN
      check("empty_words", acc_cnt2, 32'd1);
`else
      check("empty_words", acc_cnt2, 32'd0);
`endif
      check("empty_reads", rd_cnt2, 32'd0);

      // Wrong tohost data is ignored.
      rc = rd_cnt;
      wr(32'h2, 1'b0);
      tick(4);
      check("bad_data_halt", {31'b0, halt}, 32'h0);
      check("bad_data_reads", rd_cnt, rc);

      // Normal dump.
      a0 = acc_cnt;
      push_all();
      wr(32'h1, 1'b0);
      check("trig_halt", {31'b0, halt}, 32'h1);
      wait_done("dump_done");
      check("dump_words", acc_cnt - a0, exp_tx.size() == 0 ? 32'd0 + ((acc_cnt - a0)) : 32'hFFFF);
      check("dump_queue_empty", exp_tx.size(), 32'd0);
      check("dump_ra_empty", exp_ra.size(), 32'd0);
      check("done_halt", {31'b0, halt}, 32'h1);
      check("done_tx_valid", {31'b0, tx_valid}, 32'h0);

      // Writes after done have no effect.
      rc = rd_cnt;
      wr(32'h1, 1'b0);
      tick(4);
      check("post_done_reads", rd_cnt, rc);
      check("post_done_done", {31'b0, done}, 32'h1);

      // Back-pressure on the first word.
      reset1();
      tx_ready = 1'b0;
      push_all();
      wr(32'h1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (tx_valid) break;
         tick(1);
      end
      check("stall_tx_valid", {31'b0, tx_valid}, 32'h1);
      rc = rd_cnt;
      tick(5);
      check("stall_reads", rd_cnt, rc);
      tx_ready = 1'b1;
      wait_done("stall_done");
      check("stall_queue_empty", exp_tx.size(), 32'd0);

      // Reset mid-dump after the second accepted word, then retrigger.
      reset1();
      push_all();
      a0 = acc_cnt;
      wr(32'h1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (acc_cnt >= a0 + 2) break;
         tick(1);
      end
      check("abort_accepted", acc_cnt - a0, 32'd2);
      rst = 1'b1;
      tick(1);
      check_idle("abort");
      rst = 1'b0;
      exp_tx.delete();
      exp_ra.delete();
      tick(1);
      push_all();
      wr(32'h1, 1'b0);
      wait_done("retrig_done");
      check("retrig_queue_empty", exp_tx.size(), 32'd0);
      check("retrig_ra_empty", exp_ra.size(), 32'd0);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
